// File: rtl/vga_display_engine_pkg.sv
// vga_pkg: flash FSM states, default 640x480@60 timing and counter widths
package vga_pkg;
  typedef enum logic [1:0] {IDLE, SHOW_OK, SHOW_BAD} flash_state_t;
  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
endpackage

// File: rtl/vga_display_engine_if.sv
// vga_if: renderer coordinates, feedback strobe and VGA connector signals
interface vga_if #(parameter int COLOR_W = 4);
  import vga_pkg::*;
  logic fg_on;
  logic fb_strobe;
  logic fb_correct;
  logic pix_en;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic active;
  logic frame_start;
  logic vga_hsync;
  logic vga_vsync;
  logic [COLOR_W-1:0] vga_red;
  logic [COLOR_W-1:0] vga_green;
  logic [COLOR_W-1:0] vga_blue;
  modport master (
    input fg_on, fb_strobe, fb_correct,
    output pix_en, pix_x, pix_y, active, frame_start, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue
  );
  modport slave (
    output fg_on, fb_strobe, fb_correct,
    input pix_en, pix_x, pix_y, active, frame_start, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue
  );
endinterface

// File: rtl/vga_display_engine_timing.sv
// vga_timing: pixel-enable divider, h/v counters, sync/active decode and frame_start
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en,
  output logic [X_W-1:0] h,
  output logic [Y_W-1:0] v,
  output logic active,
  output logic frame_start,
  output logic hs_win,
  output logic vs_win
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [D_W-1:0] D_LAST = D_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_ACT = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] HS_LO = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_HI = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] VS_LO = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_HI = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [D_W-1:0] div;
  logic run;
  assign pix_en = run && div == D_LAST;
  assign active = h < H_ACT && v < V_ACT;
  assign hs_win = h >= HS_LO && h < HS_HI;
  assign vs_win = v >= VS_LO && v < VS_HI;
  assign frame_start = pix_en && h == H_LAST && v == V_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      run <= 1'b0;
      h <= '0;
      v <= '0;
    end else begin
      run <= 1'b1;
      div <= div == D_LAST ? '0 : div + 1'b1;
      if (pix_en) begin
        h <= h == H_LAST ? '0 : h + 1'b1;
        if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_display_engine.sv
// vga_display_engine: VGA timing plus foreground/feedback-box compositing with registered RGB and syncs
module vga_display_engine import vga_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV = 4,
  parameter int COLOR_W = 4,
  parameter int BOX_X = 560,
  parameter int BOX_Y = 20,
  parameter int BOX_W = 50,
  parameter int BOX_H = 25,
  parameter int FLASH_FRAMES = 30
) (
  input logic clk,
  input logic reset,
  vga_if.master bus
);
  localparam int C_W = FLASH_FRAMES > 0 ? $clog2(FLASH_FRAMES + 1) : 1;
  localparam logic [C_W-1:0] C_LOAD = C_W'(FLASH_FRAMES);
  localparam logic [X_W-1:0] BX_LO = X_W'(BOX_X);
  localparam logic [X_W-1:0] BX_HI = X_W'(BOX_X + BOX_W);
  localparam logic [Y_W-1:0] BY_LO = Y_W'(BOX_Y);
  localparam logic [Y_W-1:0] BY_HI = Y_W'(BOX_Y + BOX_H);
  localparam logic [COLOR_W-1:0] ONES = '1;
  logic pix_en, active, frame_start, hs_win, vs_win;
  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  flash_state_t state, state_n;
  logic [C_W-1:0] cnt, cnt_n;
  logic in_box, show_ok, show_bad, white;
  logic hs_q, vs_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .h(h),
    .v(v),
    .active(active),
    .frame_start(frame_start),
    .hs_win(hs_win),
    .vs_win(vs_win)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  // a strobe outranks a coincident frame_start: reload without decrementing
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (FLASH_FRAMES > 0 && bus.fb_strobe) begin
      state_n = bus.fb_correct ? SHOW_OK : SHOW_BAD;
      cnt_n = C_LOAD;
    end else if (state != IDLE && frame_start) begin
      state_n = cnt == C_W'(1) ? IDLE : state;
      cnt_n = cnt - 1'b1;
    end
  end
  assign in_box = active && h >= BX_LO && h < BX_HI && v >= BY_LO && v < BY_HI;
  assign show_ok = in_box && state == SHOW_OK;
  assign show_bad = in_box && state == SHOW_BAD;
  assign white = active && !show_ok && !show_bad && bus.fg_on;
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q <= ~HSYNC_POL;
      vs_q <= ~VSYNC_POL;
      red_q <= '0;
      green_q <= '0;
      blue_q <= '0;
    end else if (pix_en) begin
      hs_q <= hs_win ? HSYNC_POL : ~HSYNC_POL;
      vs_q <= vs_win ? VSYNC_POL : ~VSYNC_POL;
      red_q <= show_bad || white ? ONES : '0;
      green_q <= show_ok || white ? ONES : '0;
      blue_q <= white ? ONES : '0;
    end
  end
  assign bus.pix_en = pix_en;
  assign bus.pix_x = h;
  assign bus.pix_y = v;
  assign bus.active = active;
  assign bus.frame_start = frame_start;
  assign bus.vga_hsync = hs_q;
  assign bus.vga_vsync = vs_q;
  assign bus.vga_red = red_q;
  assign bus.vga_green = green_q;
  assign bus.vga_blue = blue_q;
endmodule

// File: tb/tb_vga_display_engine.sv
// tb_vga_display_engine: randomized scoreboard check of timing, compositing and feedback flashing
module tb_vga_display_engine;
  localparam int D = 4;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int BX = 4, BY = 2, BW = 5, BH = 3, FF = 3;
  localparam int CYCLES = 14000;
  typedef logic [13:0] px_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int tests = 0;
  int fails = 0;
  bit prev_pe = 1'b0;
  bit drv_done = 1'b0;
  px_t q[$];
  vga_if #(.COLOR_W(4)) bus ();
  vga_if #(.COLOR_W(4)) bus1 ();
  always #5 clk = ~clk;
  vga_display_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(D), .COLOR_W(4),
    .BOX_X(BX), .BOX_Y(BY), .BOX_W(BW), .BOX_H(BH), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );
  vga_display_engine #(.CLK_DIV(1)) dut1 (
    .clk(clk),
    .reset(rst1),
    .bus(bus1)
  );
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask
  // pixel index reached after k clk edges since reset release
  function automatic int pix_n(input int k);
    return k / D;
  endfunction
  function automatic bit pe_of(input int k);
    return k >= 1 && (k + 1) % D == 0;
  endfunction
  function automatic bit fs_of(input int k);
    int n;
    n = pix_n(k);
    return pe_of(k) && n % HT == HT - 1 && (n / HT) % VT == VT - 1;
  endfunction
  function automatic px_t exp_px(input int h, input int v, input bit fg, input int st);
    bit act, box, hs, vs;
    logic [3:0] r, g, b;
    act = h < HA && v < VA;
    box = h >= BX && h < BX + BW && v >= BY && v < BY + BH;
    hs = !(h >= HA + HF && h < HA + HF + HS);
    vs = !(v >= VA + VF && v < VA + VF + VS);
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    if (act && box && st == 1) g = 4'hF;
    else if (act && box && st == 2) r = 4'hF;
    else if (act && fg) begin
      r = 4'hF;
      g = 4'hF;
      b = 4'hF;
    end
    return {hs, vs, r, g, b};
  endfunction
  always @(negedge clk) begin
    if (prev_pe) begin
      if (q.size() == 0) begin
        if (!drv_done) begin
          tests++;
          fails++;
          $display("FAIL pixel_out got=unexpected_pixel want=none at %0t", $time);
        end
      end else
        check("pixel_out", 64'({bus.vga_hsync, bus.vga_vsync, bus.vga_red, bus.vga_green, bus.vga_blue}), 64'(q.pop_front()));
    end
    prev_pe = bus.pix_en;
  end
  initial begin
    int k, st, left, n, h, v;
    bit s_drv, c_drv, fg, s, cor, pe, fs;
    bus.fg_on = 1'b0;
    bus.fb_strobe = 1'b0;
    bus.fb_correct = 1'b0;
    bus1.fg_on = 1'b1;
    bus1.fb_strobe = 1'b0;
    bus1.fb_correct = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'({bus.pix_en, bus.frame_start, bus.pix_x, bus.pix_y, bus.vga_hsync, bus.vga_vsync, bus.vga_red, bus.vga_green, bus.vga_blue}),
          64'({1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b1, 12'h000}));
    rst = 1'b0;
    k = 0;
    st = 0;
    left = 0;
    s_drv = 1'b0;
    c_drv = 1'b0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      if (s_drv) begin
        st = c_drv ? 1 : 2;
        left = FF;
      end else if (st != 0 && fs_of(k)) begin
        left--;
        if (left == 0) st = 0;
      end
      k++;
      n = pix_n(k);
      h = n % HT;
      v = (n / HT) % VT;
      pe = pe_of(k);
      fs = fs_of(k);
      check("timing", 64'({bus.pix_en, bus.frame_start, bus.active, bus.pix_x, bus.pix_y}),
            64'({pe, fs, h < HA && v < VA, 11'(h), 10'(v)}));
      fg = 1'($urandom_range(0, 1));
      cor = 1'($urandom_range(0, 1));
      s = 1'b0;
      if (fs && $urandom_range(0, 2) == 0) s = 1'b1;
      else if (st == 2 && left == 1 && $urandom_range(0, 99) == 0) begin
        s = 1'b1;
        cor = 1'b1;
      end else if ($urandom_range(0, 1999) == 0) s = 1'b1;
      bus.fg_on = fg;
      bus.fb_strobe = s;
      bus.fb_correct = cor;
      s_drv = s;
      c_drv = cor;
      if (pe) q.push_back(exp_px(h, v, fg, st));
    end
    drv_done = 1'b1;
    bus.fb_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rst1 = 1'b0;
    for (int i = 0; i < 2000 && bus1.pix_x != 11'd300; i++) @(negedge clk);
    check("reach_h300", 64'({bus1.pix_x, bus1.pix_y, bus1.vga_red, bus1.vga_green, bus1.vga_blue}),
          64'({11'd300, 10'd0, 12'hFFF}));
    rst1 = 1'b1;
    @(negedge clk);
    check("mid_line_reset", 64'({bus1.pix_en, bus1.frame_start, bus1.pix_x, bus1.pix_y, bus1.vga_hsync, bus1.vga_vsync, bus1.vga_red, bus1.vga_green, bus1.vga_blue}),
          64'({1'b0, 1'b0, 11'd0, 10'd0, 1'b1, 1'b1, 12'h000}));
    rst1 = 1'b0;
    @(negedge clk);
    check("first_clk_after_release", 64'({bus1.pix_en, bus1.pix_x, bus1.pix_y, bus1.vga_red}), 64'({1'b1, 11'd0, 10'd0, 4'h0}));
    @(negedge clk);
    check("second_clk_after_release", 64'({bus1.pix_en, bus1.pix_x, bus1.vga_hsync, bus1.vga_red, bus1.vga_green, bus1.vga_blue}),
          64'({1'b1, 11'd1, 1'b1, 12'hFFF}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_display_engine.md
Name: vga_display_engine

Overview:
- Parametrised successor to the single-mode VGA front end.
- Generates programmable VGA timing from the system clock through an internal pixel-enable divider.
- Exposes pixel coordinates to content renderers and composites their foreground bit with a timed correct/wrong feedback box.
- Outputs are pipeline-aligned multi-bit RGB plus H/V sync, driven straight to the board VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CLK_DIV, 4, clk cycles per pixel (>=1; 100 MHz -> 25 MHz)
COLOR_W, 4, bits per colour channel
BOX_X, BOX_Y, 560, 20, feedback box top-left corner
BOX_W, BOX_H, 50, 25, feedback box size
FLASH_FRAMES, 30, frames the feedback box stays lit (0 disables it)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fg_on  in  1  renderer foreground bit for the current pix_x/pix_y
fb_strobe  in  1  one-clk pulse: new answer feedback
fb_correct  in  1  qualifies fb_strobe: 1 = correct, 0 = wrong
pix_en  out  1  pixel-rate enable, high one clk per pixel
pix_x  out  11  current horizontal counter (unregistered copy of the counter)
pix_y  out  10  current vertical counter
active  out  1  pix_x < H_ACTIVE and pix_y < V_ACTIVE
frame_start  out  1  one-clk pulse when the counters wrap to (0,0)
vga_hsync  out  1  registered horizontal sync
vga_vsync  out  1  registered vertical sync
vga_red, vga_green, vga_blue  out  COLOR_W each  registered colour

Behaviour:
- Reset values: divider=0, h=0, v=0, pix_en=0, frame_start=0, syncs at the inactive level (~POL), all RGB=0, flash state IDLE, frame count 0.
- Divider: counts 0..CLK_DIV-1. pix_en=1 when the count equals CLK_DIV-1. With CLK_DIV=1, pix_en is constantly 1 after reset.
- Counters advance only when pix_en=1.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way.
  - h wraps from H_TOTAL-1 to 0, and v increments on each h wrap.
  - v wraps from V_TOTAL-1 to 0.
- Sync windows:
  - hsync is asserted (=HSYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted likewise on v.
- frame_start = pix_en & h==H_TOTAL-1 & v==V_TOTAL-1, i.e. the last clk of the frame.
- Output stage:
  - Registered on pix_en: syncs and RGB reflect the counter value held during the preceding pixel period. Latency is 1 pixel.
  - Renderers must supply fg_on combinationally from pix_x/pix_y in the same period.
- Colour priority:
  1. Outside the active region: RGB=0.
  2. Inside the box (BOX_X<=h<BOX_X+BOX_W, BOX_Y<=v<BOX_Y+BOX_H) and state SHOW_OK: green all-ones, red and blue 0.
  3. Inside the box and state SHOW_BAD: red all-ones, green and blue 0.
  4. fg_on=1: all channels all-ones (white).
  5. Otherwise: 0.
- Flash FSM states: IDLE, SHOW_OK, SHOW_BAD.
  - fb_strobe (any state, FLASH_FRAMES>0) moves to SHOW_OK if fb_correct=1, else SHOW_BAD, and loads cnt=FLASH_FRAMES.
  - In SHOW_*, frame_start decrements cnt. A decrement from 1 goes to IDLE.
  - fb_strobe coincident with frame_start: the strobe wins (reload, no decrement).
  - A re-strobe while showing restarts the count and may switch the colour.
  - FLASH_FRAMES=0: strobes are ignored and the FSM stays IDLE.
- cnt width is $clog2(FLASH_FRAMES+1). All coordinate compares are unsigned at counter width.
- Reset asserted mid-frame returns everything to the reset values on the next clk edge. Output restarts at (0,0) CLK_DIV clks after reset deasserts.

Decomposition:
- Package vga_pkg holds:
  - flash_state_t enum {IDLE, SHOW_OK, SHOW_BAD};
  - default 640x480@60 timing localparams;
  - counter width constants (X_W=11, Y_W=10).
- Sub-module vga_timing contains the divider, h/v counters, sync/active decode and frame_start.
- vga_display_engine contains the flash FSM, box decode and output pipeline register.

Test Plan:
1. Reset then run with defaults:
   - pix_en period is 4 clk;
   - hsync low for exactly 96 pixels (384 clk) starting at h=656;
   - line = 3200 clk;
   - frame_start every 1,680,000 clk.
2. fg_on=1 held constant:
   - RGB=4'hF on all channels only for active pixels, exactly 1 pixel after the counters;
   - RGB=0 in blanking.
3. fb_strobe with fb_correct=1, FLASH_FRAMES=3: box pixels show green=F and red=0 for 3 full frames, then revert to the fg_on colour on the 4th.
4. fb_strobe with fb_correct=0 issued in the same clk as frame_start: state SHOW_BAD, cnt=3 with no decrement, red box.
5. Re-strobe correct during SHOW_BAD with cnt=1: switches to SHOW_OK with cnt reloaded to 3.
6. CLK_DIV=1 and reset asserted mid-line at h=300:
   - next clk h=v=0, syncs inactive, RGB=0;
   - pix_en=1 on the first clk after deassert.
